axi_io_pmp_ar_ctrl: RTL and testbench

//  Read-channel enforcement sequencer for the AXI IO-PMP; sits between s_axi AR/R and m_axi AR/R.

---
 rtl/axi_io_pmp_pkg.sv | 33 +++
 rtl/axi_io_pmp_err_burst.sv | 56 +++++
 rtl/axi_io_pmp_ar_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_axi_io_pmp_ar_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_io_pmp_pkg.sv
// Shared types and constants for the AXI IO-PMP read-channel enforcement logic.
package axi_io_pmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FWD,
    DRAIN,
    ERR
  } ar_ctrl_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Encodings of riscv::priv_lvl_t used on the pmp interface.
  localparam logic [1:0] PRIV_LVL_U = 2'b00;
  localparam logic [1:0] PRIV_LVL_S = 2'b01;

  // AXI fixed-width AR fields.
  localparam int unsigned AXI_LEN_W    = 8;
  localparam int unsigned AXI_SIZE_W   = 3;
  localparam int unsigned AXI_BURST_W  = 2;
  localparam int unsigned AXI_CACHE_W  = 4;
  localparam int unsigned AXI_PROT_W   = 3;
  localparam int unsigned AXI_QOS_W    = 4;
  localparam int unsigned AXI_REGION_W = 4;

  // arprot[0] distinguishes privileged from unprivileged accesses.
  function automatic logic [1:0] prot_to_priv(input logic prot0);
    return prot0 ? PRIV_LVL_S : PRIV_LVL_U;
  endfunction

endpackage

// File: rtl/axi_io_pmp_err_burst.sv
// Generates a locally answered DECERR read burst on the upstream R channel.
module axi_io_pmp_err_burst
  import axi_io_pmp_pkg::*;
#(
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RUSER_WIDTH = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   active_i,
  input  logic [ID_WIDTH-1:0]    id_i,
  input  logic [AXI_LEN_W-1:0]   len_i,
  input  logic                   rready_i,
  output logic                   rvalid_o,
  output logic [ID_WIDTH-1:0]    rid_o,
  output logic [DATA_WIDTH-1:0]  rdata_o,
  output logic [1:0]             rresp_o,
  output logic                   rlast_o,
  output logic [RUSER_WIDTH-1:0] ruser_o,
  output logic                   done_o
);

  logic [AXI_LEN_W-1:0] beat_q, beat_d;
  logic                 last_beat;

  assign last_beat = (beat_q == len_i);
  assign rvalid_o  = active_i;
  assign rid_o     = id_i;
  assign rdata_o   = '0;
  assign rresp_o   = RESP_DECERR;
  assign rlast_o   = last_beat;
  assign ruser_o   = '0;
  assign done_o    = active_i && rready_i && last_beat;

  // Beat counter: cleared on burst start, advances per accepted beat, wraps to 0 after the last one.
  always_comb begin
    beat_d = beat_q;
    if (start_i) begin
      beat_d = '0;
    end else if (active_i && rready_i) begin
      beat_d = last_beat ? '0 : beat_q + 1'b1;
    end
  end

  // Beat counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/axi_io_pmp_ar_ctrl.sv
// Read-channel enforcement sequencer: checks each AR against an external pmp,
// forwards allowed reads and answers denied ones with an ordered DECERR burst.
module axi_io_pmp_ar_ctrl
  import axi_io_pmp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ID_WIDTH        = 8,
  parameter int unsigned ARUSER_WIDTH    = 1,
  parameter int unsigned RUSER_WIDTH     = 1,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic [AXI_LEN_W-1:0]      s_axi_arlen,
  input  logic [AXI_SIZE_W-1:0]     s_axi_arsize,
  input  logic [AXI_BURST_W-1:0]    s_axi_arburst,
  input  logic                      s_axi_arlock,
  input  logic [AXI_CACHE_W-1:0]    s_axi_arcache,
  input  logic [AXI_PROT_W-1:0]     s_axi_arprot,
  input  logic [AXI_QOS_W-1:0]      s_axi_arqos,
  input  logic [AXI_REGION_W-1:0]   s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0]   s_axi_aruser,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [ID_WIDTH-1:0]       s_axi_rid,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]    s_axi_ruser,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [ID_WIDTH-1:0]       m_axi_arid,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [AXI_LEN_W-1:0]      m_axi_arlen,
  output logic [AXI_SIZE_W-1:0]     m_axi_arsize,
  output logic [AXI_BURST_W-1:0]    m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [AXI_CACHE_W-1:0]    m_axi_arcache,
  output logic [AXI_PROT_W-1:0]     m_axi_arprot,
  output logic [AXI_QOS_W-1:0]      m_axi_arqos,
  output logic [AXI_REGION_W-1:0]   m_axi_arregion,
  output logic [ARUSER_WIDTH-1:0]   m_axi_aruser,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [ID_WIDTH-1:0]       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic [RUSER_WIDTH-1:0]    m_axi_ruser,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic [ADDR_WIDTH-1:0]     pmp_addr_o,
  output logic [1:0]                pmp_priv_o,
  input  logic                      pmp_allow_i,
  output logic                      deny_o,
  output logic [15:0]               deny_cnt_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  // Full AR payload; widths follow this instance's parameters.
  typedef struct packed {
    logic [ID_WIDTH-1:0]     id;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [AXI_LEN_W-1:0]    len;
    logic [AXI_SIZE_W-1:0]   size;
    logic [AXI_BURST_W-1:0]  burst;
    logic                    lock;
    logic [AXI_CACHE_W-1:0]  cache;
    logic [AXI_PROT_W-1:0]   prot;
    logic [AXI_QOS_W-1:0]    qos;
    logic [AXI_REGION_W-1:0] region;
    logic [ARUSER_WIDTH-1:0] user;
  } ar_chan_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  ar_ctrl_state_e   state_q, state_d;
  ar_chan_t         s_ar, hold_q, hold_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             deny_q, deny_d;
  logic [15:0]      deny_cnt_q, deny_cnt_d;
  logic             err_start, err_active, err_done;
  logic             ar_hs, r_done;

  logic                   eb_rvalid, eb_rlast;
  logic [ID_WIDTH-1:0]    eb_rid;
  logic [DATA_WIDTH-1:0]  eb_rdata;
  logic [1:0]             eb_rresp;
  logic [RUSER_WIDTH-1:0] eb_ruser;

  assign s_ar = '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen, size: s_axi_arsize,
                  burst: s_axi_arburst, lock: s_axi_arlock, cache: s_axi_arcache,
                  prot: s_axi_arprot, qos: s_axi_arqos, region: s_axi_arregion,
                  user: s_axi_aruser};

  assign m_axi_arid     = hold_q.id;
  assign m_axi_araddr   = hold_q.addr;
  assign m_axi_arlen    = hold_q.len;
  assign m_axi_arsize   = hold_q.size;
  assign m_axi_arburst  = hold_q.burst;
  assign m_axi_arlock   = hold_q.lock;
  assign m_axi_arcache  = hold_q.cache;
  assign m_axi_arprot   = hold_q.prot;
  assign m_axi_arqos    = hold_q.qos;
  assign m_axi_arregion = hold_q.region;
  assign m_axi_aruser   = hold_q.user;

  assign pmp_addr_o = hold_q.addr;
  assign pmp_priv_o = prot_to_priv(hold_q.prot[0]);
  assign deny_o     = deny_q;
  assign deny_cnt_o = deny_cnt_q;

  // Reset takes the error driver off the bus immediately so R reverts to passthrough.
  assign err_active = (state_q == ERR) && !rst;

  // Sequencer next-state and AR-side handshake decode.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    deny_d        = 1'b0;
    deny_cnt_d    = deny_cnt_q;
    err_start     = 1'b0;
    s_axi_arready = 1'b0;
    m_axi_arvalid = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_axi_arready = !rst;
        if (s_axi_arvalid && s_axi_arready) begin
          hold_d  = s_ar;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (!pmp_allow_i) begin
          state_d    = DRAIN;
          deny_d     = 1'b1;
          deny_cnt_d = sat_inc16(deny_cnt_q);
        end else if (outstanding_q < OUT_MAX) begin
          state_d = FWD;
        end
      end
      FWD: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        // Error beats may only start once every earlier forwarded read has finished.
        if (outstanding_q == '0) begin
          state_d   = ERR;
          err_start = 1'b1;
        end
      end
      ERR: begin
        if (err_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding forwarded-read tracker; a simultaneous issue and completion cancel out.
  always_comb begin
    ar_hs         = m_axi_arvalid && m_axi_arready;
    r_done        = m_axi_rvalid && m_axi_rready && m_axi_rlast;
    outstanding_d = outstanding_q;
    if (ar_hs && !r_done && (outstanding_q != OUT_MAX)) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!ar_hs && r_done && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  // Upstream R mux: passthrough except while the local error burst owns the channel.
  always_comb begin
    s_axi_rvalid = m_axi_rvalid;
    s_axi_rid    = m_axi_rid;
    s_axi_rdata  = m_axi_rdata;
    s_axi_rresp  = m_axi_rresp;
    s_axi_rlast  = m_axi_rlast;
    s_axi_ruser  = m_axi_ruser;
    m_axi_rready = s_axi_rready;
    if (err_active) begin
      s_axi_rvalid = eb_rvalid;
      s_axi_rid    = eb_rid;
      s_axi_rdata  = eb_rdata;
      s_axi_rresp  = eb_rresp;
      s_axi_rlast  = eb_rlast;
      s_axi_ruser  = eb_ruser;
      m_axi_rready = 1'b0;
    end
  end

  // State, held request and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_q        <= '0;
      outstanding_q <= '0;
      deny_q        <= 1'b0;
      deny_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      outstanding_q <= outstanding_d;
      deny_q        <= deny_d;
      deny_cnt_q    <= deny_cnt_d;
    end
  end

  axi_io_pmp_err_burst #(
    .ID_WIDTH    (ID_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .RUSER_WIDTH (RUSER_WIDTH)
  ) u_err_burst (
    .clk      (clk),
    .rst      (rst),
    .start_i  (err_start),
    .active_i (err_active),
    .id_i     (hold_q.id),
    .len_i    (hold_q.len),
    .rready_i (s_axi_rready),
    .rvalid_o (eb_rvalid),
    .rid_o    (eb_rid),
    .rdata_o  (eb_rdata),
    .rresp_o  (eb_rresp),
    .rlast_o  (eb_rlast),
    .ruser_o  (eb_ruser),
    .done_o   (err_done)
  );

endmodule

// File: tb/tb_axi_io_pmp_ar_ctrl.sv
// Directed bench for axi_io_pmp_ar_ctrl with a one-region pmp model (0x0..0xF allowed).
module tb_axi_io_pmp_ar_ctrl;
  import axi_io_pmp_pkg::*;

  logic        clk, rst;
  logic [7:0]  s_axi_arid, m_axi_arid, s_axi_rid, m_axi_rid;
  logic [31:0] s_axi_araddr, m_axi_araddr, s_axi_rdata, m_axi_rdata, pmp_addr;
  logic [7:0]  s_axi_arlen, m_axi_arlen;
  logic [2:0]  s_axi_arsize, m_axi_arsize, s_axi_arprot, m_axi_arprot;
  logic [1:0]  s_axi_arburst, m_axi_arburst, s_axi_rresp, m_axi_rresp, pmp_priv;
  logic        s_axi_arlock, m_axi_arlock;
  logic [3:0]  s_axi_arcache, m_axi_arcache, s_axi_arqos, m_axi_arqos, s_axi_arregion, m_axi_arregion;
  logic [0:0]  s_axi_aruser, m_axi_aruser, s_axi_ruser, m_axi_ruser;
  logic        s_axi_arvalid, s_axi_arready, m_axi_arvalid, m_axi_arready;
  logic        s_axi_rvalid, s_axi_rready, s_axi_rlast, m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic        pmp_allow, deny_o;
  logic [15:0] deny_cnt, exp_deny;

  int n_pass = 0, n_tot = 0;
  int deny_pulses = 0, arv_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    logic [2:0]  prot;
    logic        allow;
    logic [1:0]  priv;
  } vec_t;
  vec_t vecs[7];

  axi_io_pmp_ar_ctrl #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .pmp_addr_o(pmp_addr), .pmp_priv_o(pmp_priv), .pmp_allow_i(pmp_allow),
    .deny_o(deny_o), .deny_cnt_o(deny_cnt)
  );

  // pmp entry 0: NAPOT RWX region 0x0..0xF, everything else denied.
  assign pmp_allow = (pmp_addr < 32'h10);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (deny_o) deny_pulses <= deny_pulses + 1;
    if (m_axi_arvalid) arv_cnt <= arv_cnt + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one AR and returns in the cycle after the handshake (state CHECK).
  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [7:0] id,
                         input logic [2:0] prot);
    int n;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id; s_axi_arprot = prot;
    s_axi_arsize = 3'd2; s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = 4'h3;
    s_axi_arqos = 4'h9; s_axi_arregion = 4'h5; s_axi_aruser = 1'b1;
    s_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axi_arready && n < 200) begin tick(); n++; end
    if (!s_axi_arready) chk("ar_accept_timeout", 64'(0), 64'(1));
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_arvalid(input string nm);
    int n;
    n = 0;
    while (!m_axi_arvalid && n < 50) begin tick(); n++; end
    chk(nm, 64'(m_axi_arvalid), 64'(1));
  endtask

  // Downstream returns nbeats of OKAY data; each must pass through unchanged.
  task automatic return_r(input logic [7:0] id, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      m_axi_rvalid = 1'b1; m_axi_rid = id; m_axi_rdata = 32'hCAFEF00D + 32'(b);
      m_axi_rresp = 2'b00; m_axi_rlast = (b == nbeats - 1); m_axi_ruser = 1'b1;
      s_axi_rready = 1'b1;
      #1;
      chk("pt_rvalid", 64'(s_axi_rvalid), 64'(1));
      chk("pt_rdata", 64'(s_axi_rdata), 64'(32'hCAFEF00D + 32'(b)));
      chk("pt_rid", 64'(s_axi_rid), 64'(id));
      chk("pt_rlast", 64'(s_axi_rlast), 64'(b == nbeats - 1));
      chk("pt_rresp", 64'(s_axi_rresp), 64'(2'b00));
      chk("pt_ruser", 64'(s_axi_ruser), 64'(1));
      chk("pt_m_rready", 64'(m_axi_rready), 64'(1));
      tick();
    end
    m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_rready = 1'b0;
  endtask

  // Collects a DECERR burst of len+1 beats, optionally toggling rready.
  task automatic collect_err(input logic [7:0] id, input logic [7:0] len, input bit toggle);
    int beats, n;
    beats = 0; n = 0;
    while (beats <= int'(len) && n < 2000) begin
      s_axi_rready = toggle ? 1'(n % 2) : 1'b1;
      #1;
      if (s_axi_rvalid) begin
        chk("err_rlast", 64'(s_axi_rlast), 64'(beats == int'(len)));
        chk("err_rresp", 64'(s_axi_rresp), 64'(2'b11));
        if (beats == 0) begin
          chk("err_rid", 64'(s_axi_rid), 64'(id));
          chk("err_rdata", 64'(s_axi_rdata), 64'(0));
          chk("err_ruser", 64'(s_axi_ruser), 64'(0));
          chk("err_m_rready", 64'(m_axi_rready), 64'(0));
        end
        if (s_axi_rready) beats++;
      end
      tick();
      n++;
    end
    s_axi_rready = 1'b0;
    chk("err_beats", 64'(beats), 64'(int'(len) + 1));
    #1;
    chk("err_done_rvalid", 64'(s_axi_rvalid), 64'(0));
    chk("err_done_state", 64'(dut.state_q), 64'(IDLE));
  endtask

  task automatic run_vec(input vec_t v, input bit toggle);
    int lat, dp0, arv0;
    dp0 = deny_pulses; arv0 = arv_cnt;
    send_ar(v.addr, v.len, v.id, v.prot);
    chk("pmp_addr", 64'(pmp_addr), 64'(v.addr));
    chk("pmp_priv", 64'(pmp_priv), 64'(v.priv));
    if (v.allow) begin
      lat = 1;
      while (!m_axi_arvalid && lat < 20) begin tick(); lat++; end
      chk("fwd_latency", 64'(lat), 64'(2));
      chk("fwd_addr", 64'(m_axi_araddr), 64'(v.addr));
      chk("fwd_len", 64'(m_axi_arlen), 64'(v.len));
      chk("fwd_id", 64'(m_axi_arid), 64'(v.id));
      chk("fwd_prot", 64'(m_axi_arprot), 64'(v.prot));
      chk("fwd_misc", {m_axi_arsize, m_axi_arburst, m_axi_arlock, m_axi_arcache,
                       m_axi_arqos, m_axi_arregion, m_axi_aruser},
          {3'd2, 2'b01, 1'b0, 4'h3, 4'h9, 4'h5, 1'b1});
      tick();
      chk("outstanding_after_fwd", 64'(dut.outstanding_q), 64'(1));
      chk("state_after_fwd", 64'(dut.state_q), 64'(IDLE));
      return_r(v.id, int'(v.len) + 1);
      #1;
      chk("outstanding_after_r", 64'(dut.outstanding_q), 64'(0));
      chk("no_deny_pulse", 64'(deny_pulses - dp0), 64'(0));
      chk("one_fwd", 64'(arv_cnt - arv0), 64'(1));
    end else begin
      collect_err(v.id, v.len, toggle);
      if (exp_deny != 16'hFFFF) exp_deny = exp_deny + 16'd1;
      chk("deny_cnt", 64'(deny_cnt), 64'(exp_deny));
      chk("deny_pulse_once", 64'(deny_pulses - dp0), 64'(1));
      chk("no_fwd_on_deny", 64'(arv_cnt - arv0), 64'(0));
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0004, 8'd0,   8'h03, 3'b000, 1'b1, 2'b00};
    vecs[1] = '{32'h0000_1000, 8'd3,   8'h07, 3'b001, 1'b0, 2'b01};
    vecs[2] = '{32'h0000_0008, 8'd3,   8'h5A, 3'b001, 1'b1, 2'b01};
    vecs[3] = '{32'h0000_0010, 8'd0,   8'hFF, 3'b000, 1'b0, 2'b00};
    vecs[4] = '{32'h0000_000C, 8'd1,   8'h00, 3'b010, 1'b1, 2'b00};
    vecs[5] = '{32'hFFFF_FFF0, 8'd255, 8'h81, 3'b101, 1'b0, 2'b01};
    vecs[6] = '{32'h0000_0000, 8'd0,   8'h2C, 3'b011, 1'b1, 2'b01};

    rst = 1'b1; exp_deny = 16'd0;
    s_axi_arvalid = 1'b0; s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0;
    s_axi_arsize = '0; s_axi_arburst = '0; s_axi_arlock = 1'b0; s_axi_arcache = '0;
    s_axi_arprot = '0; s_axi_arqos = '0; s_axi_arregion = '0; s_axi_aruser = '0;
    s_axi_rready = 1'b0; m_axi_arready = 1'b1;
    m_axi_rvalid = 1'b1; m_axi_rid = 8'h00; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0; m_axi_ruser = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_arready", 64'(s_axi_arready), 64'(0));
    chk("rst_m_arvalid", 64'(m_axi_arvalid), 64'(0));
    chk("rst_deny", 64'(deny_o), 64'(0));
    chk("rst_deny_cnt", 64'(deny_cnt), 64'(0));
    chk("rst_rvalid_follow1", 64'(s_axi_rvalid), 64'(1));
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    m_axi_rvalid = 1'b0;
    #1;
    chk("rst_rvalid_follow0", 64'(s_axi_rvalid), 64'(0));
    rst = 1'b0;
    tick();
    chk("idle_arready", 64'(s_axi_arready), 64'(1));

    // Table-driven single transactions
    for (int i = 0; i < 7; i++) run_vec(vecs[i], 1'b0);

    // rready toggling inside an error burst
    run_vec('{32'h0000_4000, 8'd3, 8'h66, 3'b000, 1'b0, 2'b00}, 1'b1);

    // Ordering: denied burst waits behind an unfinished forwarded read
    send_ar(32'h4, 8'd7, 8'h01, 3'b000);
    wait_arvalid("ord_fwd_seen");
    tick();
    send_ar(32'h2000, 8'd1, 8'h09, 3'b000);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ord_drain_state", 64'(dut.state_q), 64'(DRAIN));
      chk("ord_no_early_err", 64'(s_axi_rvalid), 64'(0));
    end
    return_r(8'h01, 8);
    #1;
    chk("ord_gap_rvalid", 64'(s_axi_rvalid), 64'(0));
    chk("ord_gap_state", 64'(dut.state_q), 64'(DRAIN));
    tick();
    chk("ord_err_state", 64'(dut.state_q), 64'(ERR));
    collect_err(8'h09, 8'd1, 1'b0);
    if (exp_deny != 16'hFFFF) exp_deny = exp_deny + 16'd1;
    chk("ord_deny_cnt", 64'(deny_cnt), 64'(exp_deny));

    // Backpressure: arready stall, then outstanding limit of 2
    m_axi_arready = 1'b0;
    send_ar(32'h0, 8'd0, 8'h11, 3'b000);
    wait_arvalid("bp_fwd1_seen");
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", 64'(m_axi_arvalid), 64'(1));
      chk("bp_hold_id", 64'(m_axi_arid), 64'(8'h11));
      tick();
    end
    m_axi_arready = 1'b1;
    tick();
    send_ar(32'h4, 8'd0, 8'h12, 3'b000);
    wait_arvalid("bp_fwd2_seen");
    tick();
    chk("bp_outstanding2", 64'(dut.outstanding_q), 64'(2));
    send_ar(32'h8, 8'd0, 8'h13, 3'b000);
    for (int k = 0; k < 4; k++) begin
      chk("bp_check_state", 64'(dut.state_q), 64'(CHECK));
      chk("bp_no_arvalid", 64'(m_axi_arvalid), 64'(0));
      chk("bp_no_arready", 64'(s_axi_arready), 64'(0));
      tick();
    end
    return_r(8'h11, 1);
    wait_arvalid("bp_fwd3_seen");
    chk("bp_fwd3_id", 64'(m_axi_arid), 64'(8'h13));
    tick();
    return_r(8'h12, 1);
    return_r(8'h13, 1);
    #1;
    chk("bp_outstanding0", 64'(dut.outstanding_q), 64'(0));

    // Reset in the middle of an error burst
    begin
      int beats, n;
      send_ar(32'h3000, 8'd3, 8'h44, 3'b001);
      s_axi_rready = 1'b1; beats = 0; n = 0;
      while (beats < 2 && n < 50) begin
        #1;
        if (s_axi_rvalid) beats++;
        tick();
        n++;
      end
      #1;
      chk("mid_beat2_rvalid", 64'(s_axi_rvalid), 64'(1));
      chk("mid_beat2_rlast", 64'(s_axi_rlast), 64'(0));
      rst = 1'b1;
      #1;
      chk("mid_rst_arready", 64'(s_axi_arready), 64'(0));
      tick();
      chk("mid_rst_rvalid", 64'(s_axi_rvalid), 64'(0));
      chk("mid_rst_state", 64'(dut.state_q), 64'(IDLE));
      chk("mid_rst_outstanding", 64'(dut.outstanding_q), 64'(0));
      chk("mid_rst_deny_cnt", 64'(deny_cnt), 64'(0));
      m_axi_rvalid = 1'b1;
      #1;
      chk("mid_rst_follow", 64'(s_axi_rvalid), 64'(1));
      m_axi_rvalid = 1'b0; s_axi_rready = 1'b0; rst = 1'b0; exp_deny = 16'd0;
      tick();
    end
    run_vec('{32'h0000_3000, 8'd0, 8'h45, 3'b000, 1'b0, 2'b00}, 1'b0);

    // Saturation of the deny counter
    @(negedge clk);
    force dut.deny_cnt_q = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    release dut.deny_cnt_q;
    tick();
    exp_deny = 16'hFFFF;
    chk("sat_preload", 64'(deny_cnt), 64'(16'hFFFF));
    run_vec('{32'h0000_5000, 8'd0, 8'h50, 3'b000, 1'b0, 2'b00}, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
